// File: rtl/axi_lite_arb2.sv
// rtl/axi_lite_arb2.sv - two-master to one-slave AXI-lite round-robin arbiter
module axi_lite_arb2 #(
    parameter int C_S_AXI_ADDR_WIDTH = 64,
    parameter int C_S_AXI_DATA_WIDTH = 64
) (
    input  logic                            clk,
    input  logic                            rst,

    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   m0_awaddr,
    input  logic                            m0_awvalid,
    output logic                            m0_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   m0_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] m0_wstrb,
    input  logic                            m0_wvalid,
    output logic                            m0_wready,
    output logic [1:0]                      m0_bresp,
    output logic                            m0_bvalid,
    input  logic                            m0_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   m0_araddr,
    input  logic                            m0_arvalid,
    output logic                            m0_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   m0_rdata,
    output logic [1:0]                      m0_rresp,
    output logic                            m0_rvalid,
    input  logic                            m0_rready,

    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   m1_awaddr,
    input  logic                            m1_awvalid,
    output logic                            m1_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   m1_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] m1_wstrb,
    input  logic                            m1_wvalid,
    output logic                            m1_wready,
    output logic [1:0]                      m1_bresp,
    output logic                            m1_bvalid,
    input  logic                            m1_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   m1_araddr,
    input  logic                            m1_arvalid,
    output logic                            m1_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   m1_rdata,
    output logic [1:0]                      m1_rresp,
    output logic                            m1_rvalid,
    input  logic                            m1_rready,

    output logic [C_S_AXI_ADDR_WIDTH-1:0]   s_awaddr,
    output logic                            s_awvalid,
    input  logic                            s_awready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s_wdata,
    output logic [C_S_AXI_DATA_WIDTH/8-1:0] s_wstrb,
    output logic                            s_wvalid,
    input  logic                            s_wready,
    input  logic [1:0]                      s_bresp,
    input  logic                            s_bvalid,
    output logic                            s_bready,
    output logic [C_S_AXI_ADDR_WIDTH-1:0]   s_araddr,
    output logic                            s_arvalid,
    input  logic                            s_arready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_rdata,
    input  logic [1:0]                      s_rresp,
    input  logic                            s_rvalid,
    output logic                            s_rready,

    output logic                            grant_id,
    output logic                            busy
);

    localparam int STRB = C_S_AXI_DATA_WIDTH / 8;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WADDR = 3'd1;
    localparam logic [2:0] ST_WRESP = 3'd2;
    localparam logic [2:0] ST_RADDR = 3'd3;
    localparam logic [2:0] ST_RDATA = 3'd4;

    logic [2:0] state_q, state_d;
    logic       grant_q, grant_d;
    logic       rr_last_q, rr_last_d;
    logic       aw_done_q, aw_done_d;
    logic       w_done_q, w_done_d;

    logic [C_S_AXI_ADDR_WIDTH-1:0] g_awaddr;
    logic [C_S_AXI_ADDR_WIDTH-1:0] g_araddr;
    logic [C_S_AXI_DATA_WIDTH-1:0] g_wdata;
    logic [STRB-1:0]               g_wstrb;
    logic g_awvalid, g_wvalid, g_bready, g_arvalid, g_rready;

    logic in_waddr, in_wresp, in_raddr, in_rdata;
    logic aw_rdy, w_rdy, b_vld, ar_rdy, r_vld;
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic req0, req1, sel, sel_wreq;

    // Granted master's request-side signals, selected purely by the registered grant.
    always_comb begin
        if (grant_q) begin
            g_awaddr  = m1_awaddr;
            g_awvalid = m1_awvalid;
            g_wdata   = m1_wdata;
            g_wstrb   = m1_wstrb;
            g_wvalid  = m1_wvalid;
            g_bready  = m1_bready;
            g_araddr  = m1_araddr;
            g_arvalid = m1_arvalid;
            g_rready  = m1_rready;
        end else begin
            g_awaddr  = m0_awaddr;
            g_awvalid = m0_awvalid;
            g_wdata   = m0_wdata;
            g_wstrb   = m0_wstrb;
            g_wvalid  = m0_wvalid;
            g_bready  = m0_bready;
            g_araddr  = m0_araddr;
            g_arvalid = m0_arvalid;
            g_rready  = m0_rready;
        end
    end

    assign in_waddr = (state_q == ST_WADDR);
    assign in_wresp = (state_q == ST_WRESP);
    assign in_raddr = (state_q == ST_RADDR);
    assign in_rdata = (state_q == ST_RDATA);

    // A completed aw or w channel stays closed until the write response retires.
    assign s_awaddr  = g_awaddr;
    assign s_awvalid = in_waddr & ~aw_done_q & g_awvalid;
    assign s_wdata   = g_wdata;
    assign s_wstrb   = g_wstrb;
    assign s_wvalid  = in_waddr & ~w_done_q & g_wvalid;
    assign s_bready  = in_wresp & g_bready;
    assign s_araddr  = g_araddr;
    assign s_arvalid = in_raddr & g_arvalid;
    assign s_rready  = in_rdata & g_rready;

    assign aw_rdy = in_waddr & ~aw_done_q & s_awready;
    assign w_rdy  = in_waddr & ~w_done_q & s_wready;
    assign b_vld  = in_wresp & s_bvalid;
    assign ar_rdy = in_raddr & s_arready;
    assign r_vld  = in_rdata & s_rvalid;

    assign m0_awready = aw_rdy & ~grant_q;
    assign m1_awready = aw_rdy & grant_q;
    assign m0_wready  = w_rdy & ~grant_q;
    assign m1_wready  = w_rdy & grant_q;
    assign m0_bvalid  = b_vld & ~grant_q;
    assign m1_bvalid  = b_vld & grant_q;
    assign m0_arready = ar_rdy & ~grant_q;
    assign m1_arready = ar_rdy & grant_q;
    assign m0_rvalid  = r_vld & ~grant_q;
    assign m1_rvalid  = r_vld & grant_q;

    assign m0_bresp = s_bresp;
    assign m1_bresp = s_bresp;
    assign m0_rdata = s_rdata;
    assign m1_rdata = s_rdata;
    assign m0_rresp = s_rresp;
    assign m1_rresp = s_rresp;

    assign aw_hs = s_awvalid & s_awready;
    assign w_hs  = s_wvalid & s_wready;
    assign b_hs  = s_bvalid & s_bready;
    assign ar_hs = s_arvalid & s_arready;
    assign r_hs  = s_rvalid & s_rready;

    assign req0 = m0_awvalid | m0_arvalid;
    assign req1 = m1_awvalid | m1_arvalid;

    // On a tie the master that was not served last wins.
    assign sel      = (req0 & req1) ? ~rr_last_q : req1;
    assign sel_wreq = sel ? m1_awvalid : m0_awvalid;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_last_d = rr_last_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        case (state_q)
            ST_IDLE: begin
                if (req0 | req1) begin
                    grant_d = sel;
                    state_d = sel_wreq ? ST_WADDR : ST_RADDR;
                end
            end
            ST_WADDR: begin
                if (aw_hs) aw_done_d = 1'b1;
                if (w_hs)  w_done_d  = 1'b1;
                if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) state_d = ST_WRESP;
            end
            ST_WRESP: begin
                if (b_hs) begin
                    state_d   = ST_IDLE;
                    rr_last_d = grant_q;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            ST_RADDR: begin
                if (ar_hs) state_d = ST_RDATA;
            end
            ST_RDATA: begin
                if (r_hs) begin
                    state_d   = ST_IDLE;
                    rr_last_d = grant_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            grant_q   <= 1'b0;
            rr_last_q <= 1'b1;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_last_q <= rr_last_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    assign grant_id = grant_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: doc/axi_lite_arb2.md
# axi_lite_arb2

Two-master to one-slave AXI-lite arbiter. It lets two configuration masters share one AXI-lite register slave, such as the MMU/MMIO configuration bridge. Exactly one transaction, read or write, is in flight at a time. Masters are served round-robin, and the granted master's channels are forwarded combinationally to the slave.

## Interface
- `C_S_AXI_ADDR_WIDTH`, default 64: address width on all ports.
- `C_S_AXI_DATA_WIDTH`, default 64: data width on all ports. `STRB` = `C_S_AXI_DATA_WIDTH/8`.
- `clk`  in  1  single clock for all channels.
- `rst`  in  1  reset, synchronous, active-high.
- `mN_awaddr`/`mN_awvalid`/`mN_awready` (N=0,1)  in/in/out  ADDR/1/1  master N write-address channel.
- `mN_wdata`/`mN_wstrb`/`mN_wvalid`/`mN_wready`  in/in/in/out  DATA/STRB/1/1  master N write-data channel.
- `mN_bresp`/`mN_bvalid`/`mN_bready`  out/out/in  2/1/1  master N write-response channel.
- `mN_araddr`/`mN_arvalid`/`mN_arready`  in/in/out  ADDR/1/1  master N read-address channel.
- `mN_rdata`/`mN_rresp`/`mN_rvalid`/`mN_rready`  out/out/out/in  DATA/2/1/1  master N read-data channel.
- `s_aw*`, `s_w*`, `s_b*`, `s_ar*`, `s_r*`  mirrored  same widths  slave-side channels; `s_` valids/addr/data are outputs, `s_` readies and `s_b*`/`s_r*` payloads are inputs.
- `grant_id`  out  1  master currently granted; holds its last value when idle.
- `busy`  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, WADDR, WRESP, RADDR, RDATA.
- IDLE: build the request vector per master: `wreq_N = mN_awvalid`, `rreq_N = mN_arvalid`, `req_N = wreq_N | rreq_N`.
- Master selection: if both masters request, pick the master not equal to `rr_last`. Otherwise pick the single requester. Register the choice into `grant_id`.
- Within the granted master, a write beats a read. Next state is WADDR for a write, RADDR for a read.
- WADDR: forward the granted master's aw and w channels to the slave.
  - `aw_done` sets on `s_awvalid & s_awready`; `w_done` sets on `s_wvalid & s_wready`.
  - After its flag sets, that channel's `s_` valid and the master's ready are forced to 0.
  - aw and w may complete in either order or in the same cycle.
  - Go to WRESP in the cycle after both flags are set, or directly when the last handshake completes.
- WRESP: route `s_bvalid`/`s_bresp` to the granted master; `s_bready = mG_bready`. On the `bvalid & bready` handshake: go to IDLE, set `rr_last <= grant_id`, clear both flags.
- RADDR: forward the ar channel. On the `s_arvalid & s_arready` handshake, go to RDATA.
- RDATA: route the r channel to the granted master. On the `rvalid & rready` handshake: go to IDLE, set `rr_last <= grant_id`.
- The non-granted master sees all readies and valids at 0 at all times. Its requests stay pending; AXI requires its valids to remain asserted.
- Outside the active channel of the current state, all `s_` valids and readies are 0.
- Slave responses pass through unmodified, including SLVERR and DECERR.
- Reset values:
  - state = IDLE, `rr_last` = 1, so master 0 wins the first tie.
  - `grant_id` = 0, `busy` = 0, `aw_done` = `w_done` = 0.
  - All `m*` readies/valids and all `s_` valids/readies = 0.
- Reset mid-transaction: the FSM returns to IDLE on the next edge and the in-flight transaction is abandoned. The slave shares the same `rst`, so no response is expected afterwards.

## Timing
- One arbitration cycle. A request sampled in IDLE at cycle T is presented on `s_` at T+1 as a combinational pass-through.
- Minimum write with a zero-wait slave: aw and w handshake at T+1, bvalid seen at T+2, back in IDLE at T+3. Next arbitration happens at T+3.
- Minimum read: ar handshake at T+1, rvalid at T+2, IDLE at T+3.
- No combinational path from `m*` valids to `m*` readies outside the granted path. Ready and valid depend on registered state plus same-channel signals only.
- Back-to-back: the IDLE cycle after a completion is mandatory. There is no grant bypass.

## Test plan
- Single write from m0: addr 0x100, data 0xDEADBEEF, strb 0xFF; slave returns OKAY. Required: s_awaddr=0x100 at T+1, m0_bresp=0 delivered, m1 readies 0 throughout, `busy` 1 for 2 cycles.
- Simultaneous m0 write and m1 read after reset: m0 is served first; m1 read (addr 0x200, slave rdata 0x1234) completes next. `grant_id` sequence is 0 then 1.
- Continuous requests from both masters for 6 transactions: grants alternate 0,1,0,1,0,1, with no starvation.
- Same master raises awvalid and arvalid together: the write completes before the read. The read is issued in the following arbitration.
- Slave accepts w 3 cycles before aw, then delays bvalid by 5 cycles: w is not re-presented after `w_done`, and exactly one bresp is returned.
- Assert `rst` during RDATA with rvalid pending: the next cycle is IDLE with all outputs at reset values, `rr_last`=1, and a fresh m1-only request is granted normally.
